// File: rtl/gfx_mask_iter_if.sv
// Handshake bundle for the mask iterator: a mask-in stream and a lane-index-out stream.
// The iterator sits on the slave side; the producer/consumer sits on the master side.
interface gfx_mask_iter_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_index;
  logic             out_last;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_index, out_last
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_index, out_last
  );
endinterface

// File: rtl/gfx_mask_iter.sv
// Lane-mask iterator: accepts a WIDTH-bit mask and emits the index of each set bit,
// lowest first, one per handshake, flagging the final one with out_last.
module gfx_mask_iter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  gfx_mask_iter_if.slave    bus
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pend_r;
  logic [WIDTH-1:0] pend_s;
  logic [WIDTH-1:0] pend_drop_s;
  logic             run_s;
  logic             last_s;
  logic             accept_s;
  logic             out_hs_s;

  // Trailing-zero count; the MSB lane yields WIDTH-1, which always fits in IW bits.
  function automatic logic [IW-1:0] ctz(input logic [WIDTH-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IW'(i);
      end
    end
    return idx;
  endfunction

  assign run_s       = (state_r == RUN);
  assign pend_drop_s = pend_r & (pend_r - WIDTH'(1));
  assign last_s      = run_s && (pend_r != '0) && (pend_drop_s == '0);
  assign out_hs_s    = run_s && bus.out_ready;
  assign accept_s    = bus.in_valid && bus.in_ready;

  assign bus.out_valid = run_s;
  assign bus.out_last  = last_s;
  assign bus.out_index = run_s ? ctz(pend_r) : '0;
  assign bus.in_ready  = !flush && (!run_s || (last_s && bus.out_ready));

  // State and pending-lane registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pend_r  <= '0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
    end
  end

  // Next-state logic: flush wins, then a new mask, then retiring the current lane.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    if (flush) begin
      state_s = IDLE;
      pend_s  = '0;
    end else if (accept_s) begin
      // A zero mask is swallowed without ever entering RUN.
      if (bus.in_mask != '0) begin
        state_s = RUN;
        pend_s  = bus.in_mask;
      end else begin
        state_s = IDLE;
        pend_s  = '0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (out_hs_s && last_s) begin
            state_s = IDLE;
            pend_s  = '0;
          end else if (out_hs_s) begin
            state_s = RUN;
            pend_s  = pend_drop_s;
          end else begin
            state_s = RUN;
            pend_s  = pend_r;
          end
        end
        IDLE: begin
          state_s = IDLE;
          pend_s  = '0;
        end
        default: begin
          state_s = IDLE;
          pend_s  = '0;
        end
      endcase
    end
  end
endmodule

// File: doc/gfx_mask_iter.md
GFX_MASK_ITER -- requirements
Module: gfx_mask_iter

Interface
REQ-001 Parameter WIDTH, default 8: mask width in bits; SHALL be legal for any value >= 2.
REQ-002 Port clk  input  1: single clock; all state SHALL update on the rising edge only.
REQ-003 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 Port flush  input  1: synchronous abort of the mask in progress.
REQ-005 Port in_valid  input  1: in_mask is valid.
REQ-006 Port in_ready  output  1: block accepts a mask this cycle.
REQ-007 Port in_mask  input  WIDTH: set of lanes to iterate; bit i means lane i.
REQ-008 Port out_valid  output  1: out_index/out_last are valid.
REQ-009 Port out_ready  input  1: consumer accepts the current index.
REQ-010 Port out_index  output  $clog2(WIDTH): lane number of the lowest set bit still pending.
REQ-011 Port out_last  output  1: out_index is the final set bit of the current mask.

Function
REQ-012 State SHALL be IDLE or RUN, plus a WIDTH-bit register pend holding the bits not yet emitted.
REQ-013 in_ready SHALL equal !flush && (state==IDLE || (out_valid && out_last && out_ready)).
REQ-014 A mask SHALL be accepted on a cycle with in_valid && in_ready.
REQ-015 Accepted nonzero mask: pend <= in_mask and state <= RUN on that edge.
REQ-016 Accepted zero mask: it SHALL be consumed silently with no output; state <= IDLE.
REQ-017 out_valid SHALL equal (state==RUN); no combinational path from in_* to out_*.
REQ-018 out_index SHALL equal the count of trailing zeros of pend, computed combinationally from pend.
REQ-019 out_last SHALL equal (pend has exactly one bit set), i.e. (pend & (pend-1))==0 while in RUN.
REQ-020 On a cycle with out_valid && out_ready and !out_last, pend <= pend & (pend-1); state stays RUN.
REQ-021 On a cycle with out_valid && out_ready && out_last:
  - a new mask accepted that cycle is loaded per REQ-015/016 (back-to-back, no bubble);
  - otherwise state <= IDLE and pend <= 0.
REQ-022 While out_valid && !out_ready, pend, out_index and out_last SHALL hold stable.
REQ-023 Latency: a mask accepted at edge N SHALL present its first index at cycle N+1; each further index SHALL follow one cycle after the previous handshake.
REQ-024 Throughput: one index per cycle under continuous out_ready; a mask with k set bits occupies exactly k cycles.
REQ-025 flush SHALL force state <= IDLE and pend <= 0 on the next edge, regardless of state. Any handshake on that cycle is discarded, and in_ready is 0 per REQ-013.
REQ-026 In IDLE, out_index and out_last SHALL be 0.
REQ-027 A mask with bit WIDTH-1 set SHALL yield out_index == WIDTH-1 without overflow of out_index.

Reset
REQ-028 While rst_n is 0: state = IDLE, pend = 0, out_valid = 0, out_index = 0, out_last = 0.
REQ-029 Reset SHALL be asserted asynchronously mid-iteration, and the remaining indices SHALL be dropped.
REQ-030 in_ready SHALL be 1 on the first cycle after deassertion, provided flush is 0.

Verification
REQ-031 WIDTH=8, in_mask=8'b1010_0110, out_ready held 1:
  - indices 1, 2, 5, 7 on consecutive cycles;
  - out_last only with 7;
  - in_ready = 1 in the cycle index 7 is shown.
REQ-032 Back-to-back masks 8'h80 then 8'h01, in_valid held:
  - outputs 7 (last) then 0 (last) in consecutive cycles, no bubble;
  - then out_valid = 0.
REQ-033 in_mask=8'h00 accepted:
  - out_valid stays 0;
  - in_ready stays 1;
  - next mask 8'h04 yields index 2 one cycle after its acceptance.
REQ-034 Backpressure: mask 8'h18, out_ready = 0 for 3 cycles:
  - out_index holds at 3 with out_last = 0 throughout;
  - on release, emits 3 then 4 (last).
REQ-035 Flush and reset:
  - mask 8'hFF, flush after index 2 is accepted -> next cycle out_valid = 0, in_ready = 1;
  - repeat with rst_n pulsed low mid-mask -> same outputs immediately, asynchronously.
REQ-036 WIDTH=5, mask 5'b10001 -> indices 0, 4 (last); out_index width is 3 bits.
